// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader FSM state type and the imem geometry constants.
// No ports; imported by prog_loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_FLUSH = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } ldr_state_t;

  // Instruction word the core executes to raise its done flag.
  localparam logic [8:0] HALT_INST = 9'h1FF;
  localparam int IMEM_AW = 8;
  localparam int INST_W  = 9;

endpackage

// File: rtl/ldr_cycle_ctr.sv
// Run-cycle counter with synchronous clear, count enable and a terminal-count flag.
// Ports: clk/reset (async, active-high), clr, en in; count (CYC_W) and tc (count==TIMEOUT) out.
// clr has priority over en; the counter is never advanced past TIMEOUT by its user.
module ldr_cycle_ctr #(
  parameter int               CYC_W   = 16,
  parameter logic [CYC_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CYC_W'(1);
    end
  end

  assign tc = (count == TIMEOUT);

endmodule

// File: rtl/prog_loader.sv
// Host-side loader: packs a byte stream into 9-bit words, writes imem, then runs the core.
// Ports: clk, reset, start, in_data/in_valid/in_ready stream; imem_we/addr/wdata write port;
//        core_reset/core_done core handshake; busy, run_done, timeout, err, cycles status.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int               ADDR_W  = IMEM_AW,
  parameter int               INST_W  = prog_loader_pkg::INST_W,
  parameter int               CYC_W   = 16,
  parameter logic [CYC_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              core_reset,
  input  logic              core_done,
  output logic              busy,
  output logic              run_done,
  output logic              timeout,
  output logic              err,
  output logic [CYC_W-1:0]  cycles
);

  // A length byte of zero means a full memory image.
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  ldr_state_t        state, state_nxt;
  logic [ADDR_W:0]   remain;
  logic [7:0]        lo;
  logic [ADDR_W-1:0] index;
  logic              we_q;
  logic [INST_W-1:0] wdata_q;
  logic              run_done_q, timeout_q, err_q;
  logic              accept, go, last_word;
  logic              ctr_en, ctr_tc;

  assign accept    = in_valid & in_ready;
  assign go        = start & ((state == S_IDLE) | (state == S_DONE));
  assign last_word = (remain == (ADDR_W+1)'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LEN;
      S_LEN:          if (accept) state_nxt = S_LO;
      S_LO:           if (accept) state_nxt = S_HI;
      S_HI:           if (accept) state_nxt = last_word ? S_FLUSH : S_LO;
      S_FLUSH:        state_nxt = S_RUN;
      S_RUN:          if (core_done || ctr_tc) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready   = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b1;
    case (state)
      S_LEN, S_LO, S_HI: in_ready = 1'b1;
      S_RUN:             core_reset = 1'b0;
      S_IDLE, S_DONE:    busy = 1'b0;
      default:           ;
    endcase
  end

  // Packing, write port and sticky status. The write is registered so imem_we
  // is high exactly the cycle after the HI handshake; the address advances at
  // the end of that same write cycle, so imem_addr is the live word index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remain     <= '0;
      lo         <= '0;
      index      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      run_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (we_q) index <= index + ADDR_W'(1);
      if (go) begin
        index      <= '0;
        run_done_q <= 1'b0;
        timeout_q  <= 1'b0;
        err_q      <= 1'b0;
      end
      if (state == S_LEN && accept)
        remain <= (in_data == 8'd0) ? FULL_LEN : (ADDR_W+1)'(in_data);
      if (state == S_LO && accept)
        lo <= in_data;
      if (state == S_HI && accept) begin
        we_q    <= 1'b1;
        wdata_q <= {in_data[0], lo};
        remain  <= remain - (ADDR_W+1)'(1);
        if (|in_data[7:1]) err_q <= 1'b1;
      end
      // core_done wins if it coincides with the terminal count.
      if (state == S_RUN) begin
        if (core_done)   run_done_q <= 1'b1;
        else if (ctr_tc) timeout_q  <= 1'b1;
      end
    end
  end

  assign ctr_en = (state == S_RUN) & ~core_done & ~ctr_tc;

  ldr_cycle_ctr #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (go),
    .en    (ctr_en),
    .count (cycles),
    .tc    (ctr_tc)
  );

  assign imem_we    = we_q;
  assign imem_addr  = index;
  assign imem_wdata = wdata_q;
  assign run_done   = run_done_q;
  assign timeout    = timeout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random load sessions against a stub core.
// Ports: none. The stub core raises core_done stub_delay cycles after core_reset falls.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, imem_we, core_reset, core_done;
  logic        busy, run_done, timeout, err;
  logic [7:0]  in_data;
  logic [7:0]  imem_addr;
  logic [8:0]  imem_wdata;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;
  logic [16:0] wq[$];   // observed writes {addr, data}
  int stub_delay = 0;
  int runcnt = 0;

  always #5 clk = ~clk;

  prog_loader #(.TIMEOUT(16'd20)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .core_done  (core_done),
    .busy       (busy),
    .run_done   (run_done),
    .timeout    (timeout),
    .err        (err),
    .cycles     (cycles)
  );

  // Stub core
  always @(posedge clk) runcnt <= core_reset ? 0 : runcnt + 1;
  assign core_done = !core_reset && (runcnt >= stub_delay);

  always @(negedge clk) if (!reset && imem_we) wq.push_back({imem_addr, imem_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one byte after gap idle cycles; with noise, start pulses in the first gap cycle.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    bit hs;
    hs = 1'b0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = noise && (g == 0);
      @(negedge clk);
    end
    start = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    for (int k = 0; k < 64 && !hs; k++) begin
      hs = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("byte_handshake", {31'd0, hs}, 32'd1);
  endtask

  // Full session: model computes expected writes and status from the byte list.
  task automatic session(input string tag, input logic [7:0] bs[$], input int gap,
                         input bit noise, input int dly);
    int nw, nbad, exp_cyc;
    bit exp_err, exp_done, pulsed;
    logic [7:0] lo_b, hi_b;
    logic [16:0] exp_q[$];
    nw = (bs[0] == 8'd0) ? 256 : int'(bs[0]);
    exp_err = 1'b0;
    for (int i = 0; i < nw; i++) begin
      lo_b = bs[2*i+1];
      hi_b = bs[2*i+2];
      exp_q.push_back({8'(i), hi_b[0], lo_b});
      if (hi_b > 8'd1) exp_err = 1'b1;
    end
    exp_done = (dly <= 18);
    exp_cyc  = exp_done ? dly : 20;

    stub_delay = dly;
    wq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    foreach (bs[i]) send_byte(bs[i], gap, noise);

    pulsed = 1'b0;
    for (int k = 0; k < 200 && busy; k++) begin
      if (noise && !pulsed && !core_reset) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_finished"}, {31'd0, busy}, 32'd0);

    check({tag, "_nwrites"}, wq.size(), nw);
    nbad = 0;
    for (int i = 0; i < nw && i < wq.size(); i++)
      if (wq[i] !== exp_q[i]) nbad++;
    check({tag, "_write_mismatches"}, nbad, 0);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_run_done"}, {31'd0, run_done}, {31'd0, exp_done});
    check({tag, "_timeout"}, {31'd0, timeout}, {31'd0, !exp_done});
    check({tag, "_cycles"}, {16'd0, cycles}, exp_cyc);
    check({tag, "_core_held"}, {31'd0, core_reset}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    check({tag, "_imem_we"},    {31'd0, imem_we},    32'd0);
    check({tag, "_imem_addr"},  {24'd0, imem_addr},  32'd0);
    check({tag, "_imem_wdata"}, {23'd0, imem_wdata}, 32'd0);
    check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_run_done"},   {31'd0, run_done},   32'd0);
    check({tag, "_timeout"},    {31'd0, timeout},    32'd0);
    check({tag, "_err"},        {31'd0, err},        32'd0);
    check({tag, "_cycles"},     {16'd0, cycles},     32'd0);
  endtask

  initial begin
    logic [7:0] bs[$];
    logic [7:0] t1[$];
    int nw;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: two words, core halts after 5 run cycles
    t1 = {8'h02, 8'h34, 8'h00, 8'hFF, 8'h01};
    session("t1", t1, 0, 1'b0, 5);
    check("t1_word0", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFFFFFF, {15'd0, 8'd0, 9'h034});
    check("t1_word1", (wq.size() > 1) ? 32'(wq[1]) : 32'hFFFFFFFF, {15'd0, 8'd1, 9'h1FF});

    // 2: full 256-word image
    bs.delete();
    bs.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      bs.push_back(8'($urandom_range(0, 255)));
      bs.push_back(8'($urandom_range(0, 1)));
    end
    session("t2", bs, 0, 1'b0, 3);
    check("t2_last_addr", (wq.size() > 0) ? 32'(wq[$][16:9]) : 32'hFFFFFFFF, 32'hFF);

    // 3: HI byte with upper bits set
    bs = {8'h01, 8'h12, 8'h03};
    session("t3", bs, 0, 1'b0, 2);
    check("t3_word0", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFFFFFF, {15'd0, 8'd0, 9'h112});

    // 4: core never halts
    session("t4", t1, 0, 1'b0, 1000);

    // 5: reset in the middle of a load
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_values("t5_midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    session("t5_reload", t1, 0, 1'b0, 5);

    // 6: sparse valid and stray start pulses
    session("t6", t1, 2, 1'b1, 5);
    check("t6_word1", (wq.size() > 1) ? 32'(wq[1]) : 32'hFFFFFFFF, {15'd0, 8'd1, 9'h1FF});

    // Random sessions
    for (int r = 0; r < 6; r++) begin
      bs.delete();
      nw = $urandom_range(1, 12);
      bs.push_back(8'(nw));
      for (int i = 0; i < nw; i++) begin
        bs.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 1) == 1) bs.push_back(8'($urandom_range(0, 255)));
        else                           bs.push_back(8'($urandom_range(0, 1)));
      end
      session("rand", bs, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(0, 18));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
